exc_stack_ctrl: RTL

- Exception entry/exit sequencer for the core register file.
- On an accepted exception it pushes the 8-word frame to memory: R0-R3, R12, LR, PC, xPSR.
- It then updates SP, fetches the vector, and loads PC, LR and IPSR.
- On exception return it pops the frame back into the register file and restores SP.
- It sits between the decode/exception logic, the core register file write ports and the data-memory port, and stalls the pipeline while busy.

---
 rtl/exc_stack_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/exc_stack_ctrl.sv
// Exception entry/exit sequencer: stacks the 8-word frame on entry, fetches the
// vector, and unstacks the frame into the register file on exception return.
module exc_stack_ctrl #(
  parameter logic [31:0] VTOR_BASE  = 32'h0000_0000,
  parameter logic [31:0] EXC_RETURN = 32'hFFFF_FFF9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [5:0]  exc_num,
  input  logic        ret_req,
  output logic        exc_ack,
  output logic        ret_ack,
  output logic        busy,
  input  logic [31:0] r_SP,
  input  logic [31:0] r_LR,
  input  logic [31:0] r_PC,
  input  logic [3:0]  r_APSR,
  input  logic [5:0]  r_IPSR,
  input  logic        r_PMask,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        ld_sp,
  output logic        ld_lr,
  output logic        ld_pc,
  output logic        ld_rd,
  output logic        ld_apsr,
  output logic        ld_ipsr,
  output logic [31:0] w_SP,
  output logic [31:0] w_LR,
  output logic [31:0] w_PC,
  output logic [31:0] w_Rd,
  output logic [3:0]  addr_Rd,
  output logic [3:0]  w_APSR,
  output logic [5:0]  w_IPSR,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    SP_DN,
    VEC,
    ENTRY_DONE,
    POP,
    SP_UP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_k;
  logic [31:0] r_base;
  logic [31:0] r_xpsr;
  logic [31:0] r_vec;
  logic [5:0]  r_num;

  logic        w_excOk;
  logic [31:0] w_frameAddr;

  // NMI and HardFault bypass PRIMASK; everything else waits while masked.
  assign w_excOk     = exc_req && (!r_PMask || exc_num == 6'd2 || exc_num == 6'd3);
  assign w_frameAddr = r_base + {27'd0, r_k, 2'b00};
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_k     <= 3'd0;
      r_base  <= 32'd0;
      r_xpsr  <= 32'd0;
      r_vec   <= 32'd0;
      r_num   <= 6'd0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (w_excOk) begin
            r_base <= r_SP - 32'd32;
            r_num  <= exc_num;
            r_xpsr <= {r_APSR, 3'b000, 1'b1, 18'd0, r_IPSR};
            r_k    <= 3'd0;
          end else if (ret_req) begin
            r_base <= r_SP;
            r_k    <= 3'd0;
          end
        end
        PUSH, POP: begin
          if (mem_ack) r_k <= r_k + 3'd1;
        end
        VEC: begin
          if (mem_ack) r_vec <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    exc_ack     = 1'b0;
    ret_ack     = 1'b0;
    rf_raddr    = 4'd0;
    ld_sp       = 1'b0;
    ld_lr       = 1'b0;
    ld_pc       = 1'b0;
    ld_rd       = 1'b0;
    ld_apsr     = 1'b0;
    ld_ipsr     = 1'b0;
    w_SP        = 32'd0;
    w_LR        = 32'd0;
    w_PC        = 32'd0;
    w_Rd        = 32'd0;
    addr_Rd     = 4'd0;
    w_APSR      = 4'd0;
    w_IPSR      = 6'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;

    case (r_state)
      IDLE: begin
        if (w_excOk)      w_nextState = PUSH;
        else if (ret_req) w_nextState = POP;
      end
      PUSH: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = w_frameAddr;
        case (r_k)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            rf_raddr  = {1'b0, r_k};
            mem_wdata = rf_rdata;
          end
          3'd4: begin
            rf_raddr  = 4'd12;
            mem_wdata = rf_rdata;
          end
          3'd5:    mem_wdata = r_LR;
          3'd6:    mem_wdata = r_PC;
          default: mem_wdata = r_xpsr;
        endcase
        if (mem_ack && r_k == 3'd7) w_nextState = SP_DN;
      end
      SP_DN: begin
        ld_sp       = 1'b1;
        w_SP        = r_base;
        w_nextState = VEC;
      end
      VEC: begin
        mem_req  = 1'b1;
        mem_addr = VTOR_BASE + {24'd0, r_num, 2'b00};
        if (mem_ack) w_nextState = ENTRY_DONE;
      end
      ENTRY_DONE: begin
        ld_pc       = 1'b1;
        w_PC        = r_vec & ~32'd1;
        ld_lr       = 1'b1;
        w_LR        = EXC_RETURN;
        ld_ipsr     = 1'b1;
        w_IPSR      = r_num;
        exc_ack     = 1'b1;
        w_nextState = IDLE;
      end
      POP: begin
        mem_req  = 1'b1;
        mem_addr = w_frameAddr;
        // Write strobes go out with the ack so the register file captures on the next negedge.
        if (mem_ack) begin
          case (r_k)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              ld_rd   = 1'b1;
              addr_Rd = {1'b0, r_k};
              w_Rd    = mem_rdata;
            end
            3'd4: begin
              ld_rd   = 1'b1;
              addr_Rd = 4'd12;
              w_Rd    = mem_rdata;
            end
            3'd5: begin
              ld_lr = 1'b1;
              w_LR  = mem_rdata;
            end
            3'd6: begin
              ld_pc = 1'b1;
              w_PC  = mem_rdata & ~32'd1;
            end
            default: begin
              ld_apsr     = 1'b1;
              w_APSR      = mem_rdata[31:28];
              ld_ipsr     = 1'b1;
              w_IPSR      = mem_rdata[5:0];
              w_nextState = SP_UP;
            end
          endcase
        end
      end
      SP_UP: begin
        ld_sp       = 1'b1;
        w_SP        = r_base + 32'd32;
        ret_ack     = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule
